// File: rtl/ifetch_queue_pkg.sv
// Shared widths and reset defaults for the instruction fetch queue.
package ifetch_queue_pkg;

   localparam int unsigned WORD      = 64;
   localparam int unsigned INSTR_LEN = 32;
   localparam int unsigned STEP      = 4;
   localparam int unsigned DEPTH     = 4;
   localparam int unsigned STAT_W    = 32;
   localparam logic [WORD-1:0] RESET_PC = '0;

endpackage

// File: rtl/ifetch_queue_fetch_fifo.sv
// Fetch queue storage: DEPTH entries with push, pop and flush.
// Flush beats push. A pop in the flush cycle still advances the read side.
module ifetch_queue_fetch_fifo #(
   parameter int unsigned WIDTH = 96,
   parameter int unsigned DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic                    push,
   input  logic [WIDTH-1:0]        push_data,
   input  logic                    pop,
   output logic [WIDTH-1:0]        head_data,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr_nxt_c;

   assign rd_ptr_nxt_c = pop ? rd_ptr + PW'(1) : rd_ptr;

   // Storage is cleared on reset so the head reads zero until the first write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         rd_ptr <= rd_ptr_nxt_c;
         wr_ptr <= rd_ptr_nxt_c;
         count  <= '0;
      end else begin
         rd_ptr <= rd_ptr_nxt_c;
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign head_data = mem[rd_ptr];

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch stage: PC, redirect mux, 1-cycle imem interface and fetch queue.
// Optional build macro FETCH_STATS_EN adds redirect and stall counters.
module ifetch_queue #(
   parameter int unsigned     WORD      = ifetch_queue_pkg::WORD,
   parameter int unsigned     INSTR_LEN = ifetch_queue_pkg::INSTR_LEN,
   parameter int unsigned     STEP      = ifetch_queue_pkg::STEP,
   parameter int unsigned     DEPTH     = ifetch_queue_pkg::DEPTH,
   parameter logic [WORD-1:0] RESET_PC  = WORD'(ifetch_queue_pkg::RESET_PC)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 redirect_valid,
   input  logic [WORD-1:0]      redirect_target,
   output logic                 imem_en,
   output logic [WORD-1:0]      imem_addr,
   input  logic [INSTR_LEN-1:0] imem_rdata,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [INSTR_LEN-1:0] out_instr,
   output logic [WORD-1:0]      out_pc,
`ifdef FETCH_STATS_EN
   output logic [ifetch_queue_pkg::STAT_W-1:0] stat_redirects,
   output logic [ifetch_queue_pkg::STAT_W-1:0] stat_stall_cycles,
`endif
   output logic [WORD-1:0]      out_incremented_pc
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned EW = INSTR_LEN + WORD;

   logic [WORD-1:0] fetch_pc;
   logic [WORD-1:0] inflight_pc;
   logic            inflight;
   logic [WORD-1:0] target_c;
   logic            redirect_c;
   logic            pop_c;
   logic            credit_c;
   logic [CW-1:0]   count;
   logic [EW-1:0]   head;
   logic            unused_target_lsbs;

   assign unused_target_lsbs = ^redirect_target[1:0];

   assign target_c   = {redirect_target[WORD-1:2], 2'b00};
   assign redirect_c = reset & redirect_valid;
   assign pop_c      = out_valid & out_ready;

   // Queue slots plus the outstanding response must never exceed DEPTH.
   assign credit_c = ((CW+1)'(count) + (CW+1)'(inflight)) < ((CW+1)'(DEPTH) + (CW+1)'(pop_c));

   assign imem_en   = reset & (redirect_valid | credit_c);
   assign imem_addr = redirect_c ? target_c : fetch_pc;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc    <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= RESET_PC;
      end else begin
         inflight <= imem_en;
         if (imem_en) begin
            inflight_pc <= imem_addr;
            fetch_pc    <= imem_addr + WORD'(STEP);
         end
      end
   end

   // A redirect flush also kills the response landing in the same cycle.
   ifetch_queue_fetch_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (reset),
      .flush     (redirect_c),
      .push      (inflight),
      .push_data ({imem_rdata, inflight_pc}),
      .pop       (pop_c),
      .head_data (head),
      .count     (count)
   );

   assign out_valid          = (count != '0);
   assign out_instr          = head[EW-1:WORD];
   assign out_pc             = head[WORD-1:0];
   assign out_incremented_pc = out_valid ? out_pc + WORD'(STEP) : '0;

`ifdef FETCH_STATS_EN
   // Saturating event counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_redirects    <= '0;
         stat_stall_cycles <= '0;
      end else begin
         if (redirect_c && (stat_redirects != '1)) begin
            stat_redirects <= stat_redirects + ifetch_queue_pkg::STAT_W'(1);
         end
         if (out_valid && !out_ready && (stat_stall_cycles != '1)) begin
            stat_stall_cycles <= stat_stall_cycles + ifetch_queue_pkg::STAT_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with an address-tagged 1-cycle memory model.
module tb_ifetch_queue;

   logic        clk;
   logic        reset;
   logic        redirect_valid;
   logic [63:0] redirect_target;
   logic        imem_en;
   logic [63:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [63:0] out_pc;
   logic [63:0] out_incremented_pc;
`ifdef FETCH_STATS_EN
   logic [31:0] stat_redirects;
   logic [31:0] stat_stall_cycles;
`endif

   int n_checks = 0;
   int n_err    = 0;

   ifetch_queue dut (
      .clk                (clk),
      .reset              (reset),
      .redirect_valid     (redirect_valid),
      .redirect_target    (redirect_target),
      .imem_en            (imem_en),
      .imem_addr          (imem_addr),
      .imem_rdata         (imem_rdata),
      .out_valid          (out_valid),
      .out_ready          (out_ready),
      .out_instr          (out_instr),
      .out_pc             (out_pc),
`ifdef FETCH_STATS_EN
      .stat_redirects     (stat_redirects),
      .stat_stall_cycles  (stat_stall_cycles),
`endif
      .out_incremented_pc (out_incremented_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return a[33:2] ^ 32'h5A5A_0000;
   endfunction

   initial imem_rdata = '0;
   always @(posedge clk) begin
      if (imem_en) imem_rdata <= mem_word(imem_addr);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic exp_v, input logic [63:0] exp_pc);
      chk({tag, "_valid"}, 64'(out_valid), 64'(exp_v));
      if (exp_v) begin
         chk({tag, "_pc"}, out_pc, exp_pc);
         chk({tag, "_incpc"}, out_incremented_pc, exp_pc + 64'd4);
         chk({tag, "_instr"}, 64'(out_instr), 64'(mem_word(exp_pc)));
      end
   endtask

   task automatic chk_fetch(input string tag, input logic exp_en, input logic [63:0] exp_addr);
      chk({tag, "_en"}, 64'(imem_en), 64'(exp_en));
      chk({tag, "_addr"}, imem_addr, exp_addr);
   endtask

   // Advance to the next cycle, drive inputs, then settle before checking.
   task automatic cyc(input logic rv, input logic [63:0] tgt, input logic rdy);
      @(negedge clk);
      redirect_valid  = rv;
      redirect_target = tgt;
      out_ready       = rdy;
      #1;
   endtask

   task automatic do_reset(input logic rdy);
      @(negedge clk);
      reset          = 1'b0;
      redirect_valid = 1'b0;
      out_ready      = rdy;
      @(negedge clk);
      reset = 1'b1;
      #1;
   endtask

   initial begin
      reset           = 1'b1;
      redirect_valid  = 1'b0;
      redirect_target = '0;
      out_ready       = 1'b1;
      #1 reset = 1'b0;
      #2;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_en", 64'(imem_en), 64'd0);
      chk("rst_addr", imem_addr, 64'd0);
      chk("rst_instr", 64'(out_instr), 64'd0);
      chk("rst_pc", out_pc, 64'd0);
      chk("rst_incpc", out_incremented_pc, 64'd0);
`ifdef FETCH_STATS_EN
      chk("rst_stat_redir", 64'(stat_redirects), 64'd0);
      chk("rst_stat_stall", 64'(stat_stall_cycles), 64'd0);
`endif

      // Streaming with decode always ready
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk_fetch("s_c0", 1'b1, 64'd0);
      chk_out("s_c0", 1'b0, 64'd0);
      for (int k = 1; k <= 7; k++) begin
         cyc(1'b0, 64'd0, 1'b1);
         chk_fetch("s_fetch", 1'b1, 64'(4 * k));
         chk_out("s_out", k >= 2, 64'(4 * (k - 2)));
      end

      // Decode stalled: queue fills to DEPTH, then drains in order
      do_reset(1'b0);
      chk_fetch("f_c0", 1'b1, 64'd0);
      for (int k = 1; k <= 9; k++) begin
         cyc(1'b0, 64'd0, 1'b0);
         chk_fetch("f_fetch", k <= 3, (k <= 3) ? 64'(4 * k) : 64'd16);
         chk_out("f_hold", k >= 2, 64'd0);
      end
      for (int k = 10; k <= 15; k++) begin
         cyc(1'b0, 64'd0, 1'b1);
         if (k == 10) chk_fetch("f_resume", 1'b1, 64'd16);
         chk_out("f_drain", 1'b1, 64'(4 * (k - 10)));
      end

      // Redirect with credits exhausted and a response in flight
      do_reset(1'b0);
      for (int k = 1; k <= 3; k++) cyc(1'b0, 64'd0, 1'b0);
      cyc(1'b1, 64'h400, 1'b0);
      chk_fetch("r_issue", 1'b1, 64'h400);
      chk_out("r_head", 1'b1, 64'd0);
      cyc(1'b0, 64'd0, 1'b0);
      chk_out("r_n1", 1'b0, 64'd0);
      chk_fetch("r_n1", 1'b1, 64'h404);
      cyc(1'b0, 64'd0, 1'b1);
      chk_out("r_n2", 1'b1, 64'h400);
      cyc(1'b0, 64'd0, 1'b1);
      chk_out("r_n3", 1'b1, 64'h404);
      cyc(1'b0, 64'd0, 1'b1);
      chk_out("r_n4", 1'b1, 64'h408);

      // Redirect coinciding with a pop, then a second redirect back-to-back
      do_reset(1'b1);
      for (int k = 1; k <= 5; k++) cyc(1'b0, 64'd0, 1'b1);
      cyc(1'b1, 64'h100, 1'b1);
      chk_out("b_pop", 1'b1, 64'h10);
      chk_fetch("b_r1", 1'b1, 64'h100);
      cyc(1'b1, 64'h200, 1'b1);
      chk_out("b_c7", 1'b0, 64'd0);
      chk_fetch("b_r2", 1'b1, 64'h200);
      cyc(1'b0, 64'd0, 1'b1);
      chk_out("b_c8", 1'b0, 64'd0);
      chk_fetch("b_c8", 1'b1, 64'h204);
      for (int k = 9; k <= 11; k++) begin
         cyc(1'b0, 64'd0, 1'b1);
         chk_out("b_stream", 1'b1, 64'h200 + 64'(4 * (k - 9)));
      end

      // Address wrap and unaligned target
      cyc(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
      chk_fetch("w_issue", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
      cyc(1'b0, 64'd0, 1'b1);
      chk_fetch("w_wrap", 1'b1, 64'd0);
      cyc(1'b0, 64'd0, 1'b1);
      chk_out("w_top", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
      cyc(1'b0, 64'd0, 1'b1);
      chk_out("w_zero", 1'b1, 64'd0);
      cyc(1'b1, 64'h103, 1'b1);
      chk_out("w_four", 1'b1, 64'd4);
      chk_fetch("u_align", 1'b1, 64'h100);
      cyc(1'b0, 64'd0, 1'b1);
      chk_out("u_n1", 1'b0, 64'd0);
      cyc(1'b0, 64'd0, 1'b1);
      chk_out("u_n2", 1'b1, 64'h100);

      // Asynchronous reset between clock edges
      cyc(1'b0, 64'd0, 1'b1);
      @(negedge clk);
      #3 reset = 1'b0;
      #1;
      chk("ar_valid", 64'(out_valid), 64'd0);
      chk("ar_en", 64'(imem_en), 64'd0);
      chk("ar_addr", imem_addr, 64'd0);
      chk("ar_pc", out_pc, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk_fetch("ar_restart", 1'b1, 64'd0);
      cyc(1'b0, 64'd0, 1'b1);
      chk_out("ar_c1", 1'b0, 64'd0);
      cyc(1'b0, 64'd0, 1'b1);
      chk_out("ar_c2", 1'b1, 64'd0);

      // Event counters: five stall cycles then three redirects
      do_reset(1'b0);
      for (int k = 1; k <= 6; k++) cyc(1'b0, 64'd0, 1'b0);
      cyc(1'b1, 64'h800, 1'b1);
      cyc(1'b1, 64'h900, 1'b1);
      cyc(1'b1, 64'hA00, 1'b1);
      cyc(1'b0, 64'd0, 1'b1);
      chk_out("st_gap", 1'b0, 64'd0);
      cyc(1'b0, 64'd0, 1'b1);
      chk_out("st_last", 1'b1, 64'hA00);
`ifdef FETCH_STATS_EN
      chk("st_redirects", 64'(stat_redirects), 64'd3);
      chk("st_stalls", 64'(stat_stall_cycles), 64'd5);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
